// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and constants for the multi-port register file.
//   state_e       : sweep FSM states (CLEAR while zeroing entries, READY afterwards)
//   NUM_RD_MAX    : largest supported number of read ports
//   clampRdPorts  : folds a requested read-port count into the supported 1..NUM_RD_MAX range
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int NUM_RD_MAX = 4;

  function automatic int clampRdPorts(input int n);
    if (n < 1) begin
      return 1;
    end else if (n > NUM_RD_MAX) begin
      return NUM_RD_MAX;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port
// One combinational read channel of the register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   mem_i        in   whole storage array, entry e at mem_i[e]
//   ready_i      in   high once the clear sweep has finished
//   rd_addr_i    in   address read by this channel
//   wr_en0_i / wr_addr0_i / wr_data0_i   in   write port 0 (bypass source)
//   wr_en1_i / wr_addr1_i / wr_data1_i   in   write port 1 (bypass source, wins on collision)
//   rd_data_o    out  read data; zero for address 0 and whenever not ready
module regfile_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_i,
  input  logic                             ready_i,
  input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
  input  logic                             wr_en0_i,
  input  logic [ADDR_WIDTH-1:0]            wr_addr0_i,
  input  logic [DATA_WIDTH-1:0]            wr_data0_i,
  input  logic                             wr_en1_i,
  input  logic [ADDR_WIDTH-1:0]            wr_addr1_i,
  input  logic [DATA_WIDTH-1:0]            wr_data1_i,
  output logic [DATA_WIDTH-1:0]            rd_data_o
);

`ifndef REGFILE_BYPASS_EN
  // Without forwarding the write ports only matter to the storage array.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en0_i, wr_addr0_i, wr_data0_i,
                           wr_en1_i, wr_addr1_i, wr_data1_i};
`endif

  // Entry 0 and the whole file during the sweep read as zero. With forwarding,
  // port 1 is checked last so it overrides port 0 on a same-address collision,
  // matching the commit priority of the storage array.
  always_comb begin
    rd_data_o = '0;
    if (ready_i && (rd_addr_i != '0)) begin
      rd_data_o = mem_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_en0_i && (wr_addr0_i == rd_addr_i)) begin
        rd_data_o = wr_data0_i;
      end
      if (wr_en1_i && (wr_addr1_i == rd_addr_i)) begin
        rd_data_o = wr_data1_i;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port integer register file with two prioritised write
// ports and a hardware zeroing sweep after reset.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   clk_i                               in   rising-edge clock
//   rst_i                               in   synchronous active-high reset, restarts the sweep
//   rd_addr_i                           in   packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data_o                           out  packed read data, same packing
//   wr_en0_i / wr_addr0_i / wr_data0_i  in   write port 0
//   wr_en1_i / wr_addr1_i / wr_data1_i  in   write port 1 (wins on same-address collision)
//   ready_o                             out  high once the sweep is done; writes accepted only then
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  input  logic                           wr_en0_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr0_i,
  input  logic [DATA_WIDTH-1:0]          wr_data0_i,
  input  logic                           wr_en1_i,
  input  logic [ADDR_WIDTH-1:0]          wr_addr1_i,
  input  logic [DATA_WIDTH-1:0]          wr_data1_i,
  output logic                           ready_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NumRdEff = clampRdPorts(NUM_RD);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(1);

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           sweepCnt_q, sweepCnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] memArray_q;
  logic                            commit0, commit1;

  // Sweep FSM state and counter. Reset always restarts the sweep at entry 1,
  // since entry 0 is never stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR;
      sweepCnt_q <= FirstAddr;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
    end
  end

  // The sweep zeroes one entry per cycle and hands over to READY once the
  // last entry has been written.
  always_comb begin
    state_d    = state_q;
    sweepCnt_d = sweepCnt_q;
    unique case (state_q)
      CLEAR: begin
        sweepCnt_d = sweepCnt_q + FirstAddr;
        if (sweepCnt_q == LastAddr) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign ready_o = (state_q == READY);

  // Port 0 is dropped when port 1 targets the same address; address 0 is
  // never committed so it stays a constant zero.
  assign commit0 = ready_o && wr_en0_i && (wr_addr0_i != '0) &&
                   !(wr_en1_i && (wr_addr1_i == wr_addr0_i));
  assign commit1 = ready_o && wr_en1_i && (wr_addr1_i != '0);

  // Storage array. During the sweep the datapath write ports are ignored, and
  // a reset cycle drops every write so a write racing reset leaves no trace.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        memArray_q[sweepCnt_q] <= '0;
      end else begin
        if (commit0) begin
          memArray_q[wr_addr0_i] <= wr_data0_i;
        end
        if (commit1) begin
          memArray_q[wr_addr1_i] <= wr_data1_i;
        end
      end
    end
  end

  // One read channel per requested port; counts outside the supported range
  // tie the surplus channels to zero.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    if (k < NumRdEff) begin : g_port
      regfile_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
      ) u_rd_port (
        .mem_i      (memArray_q),
        .ready_i    (ready_o),
        .rd_addr_i  (rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
        .wr_en0_i   (wr_en0_i),
        .wr_addr0_i (wr_addr0_i),
        .wr_data0_i (wr_data0_i),
        .wr_en1_i   (wr_en1_i),
        .wr_addr1_i (wr_addr1_i),
        .wr_data1_i (wr_data1_i),
        .rd_data_o  (rd_data_o[k*DATA_WIDTH +: DATA_WIDTH])
      );
    end else begin : g_tie
      assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp with three read ports. Expected values are
// queued by the stimulus process and compared by a separate monitor.
// Honours REGFILE_BYPASS_EN when choosing same-cycle read expectations.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rdAddr;
  logic [NR*DW-1:0]  rdData;
  logic              wrEn0;
  logic [AW-1:0]     wrAddr0;
  logic [DW-1:0]     wrData0;
  logic              wrEn1;
  logic [AW-1:0]     wrAddr1;
  logic [DW-1:0]     wrData1;
  logic              ready;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } expItem_t;

  expItem_t expQ[$];
  int cycleCnt    = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_addr_i  (rdAddr),
    .rd_data_o  (rdData),
    .wr_en0_i   (wrEn0),
    .wr_addr0_i (wrAddr0),
    .wr_data0_i (wrData0),
    .wr_en1_i   (wrEn1),
    .wr_addr1_i (wrAddr1),
    .wr_data1_i (wrData1),
    .ready_o    (ready)
  );

  // Free-running clock and cycle index used to tag expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor: mid-cycle, pop every expectation tagged for this cycle and
  // compare it with the DUT outputs.
  always @(negedge clk) begin : monitor
    expItem_t    it;
    logic [31:0] act;
    while (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
      it = expQ.pop_front();
      if (it.kind == 1) begin
        act = {31'b0, ready};
      end else begin
        act = rdData[it.port*DW +: DW];
      end
      testsRun++;
      if (it.cyc != cycleCnt) begin
        testsFailed++;
        $display("[TB] FAIL %s: stale check for cycle %0d seen at cycle %0d", it.name, it.cyc, cycleCnt);
      end else if (act !== it.exp) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  // Overall time bound so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r,
                               input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rst     = r;
    wrEn0   = e0;
    wrAddr0 = a0;
    wrData0 = d0;
    wrEn1   = e1;
    wrAddr1 = a1;
    wrData1 = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic setReads(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    rdAddr = {r2, r1, r0};
  endtask

  task automatic checkOutput(input string name, input int port, input logic [31:0] exp);
    expItem_t e;
    e.cyc  = cycleCnt;
    e.kind = 0;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkReady(input string name, input logic exp);
    expItem_t e;
    e.cyc  = cycleCnt;
    e.kind = 1;
    e.port = 0;
    e.exp  = {31'b0, exp};
    e.name = name;
    expQ.push_back(e);
  endtask

  // Directed stimulus.
  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    setReads(5'd1, 5'd2, 5'd3);

    // Reset edge, then the reset state during the first cycle with rst low.
    nextCycle();
    idle();
    checkReady("reset_ready", 1'b0);
    for (int p = 0; p < NR; p++) checkOutput($sformatf("reset_rd%0d", p), p, 32'h0);

    // Sweep: ready low for 31 cycles; a write attempt mid-sweep is ignored.
    for (int i = 0; i < 31; i++) begin
      checkReady($sformatf("sweep_ready_%0d", i), 1'b0);
      if (i == 5) begin
        applyStimulus(1'b0, 1'b1, 5'd2, 32'h1234_5678, 1'b1, 5'd4, 32'h8765_4321);
      end else begin
        idle();
      end
      if (i == 10) begin
        for (int p = 0; p < NR; p++) checkOutput($sformatf("sweep_rd%0d", p), p, 32'h0);
      end
      nextCycle();
    end
    idle();
    checkReady("ready_after_sweep", 1'b1);

    // Every entry reads zero after the sweep, including x2/x4 written mid-sweep.
    for (int a = 1; a < 32; a += 3) begin
      setReads(5'(a), 5'(a + 1), 5'(a + 2));
      for (int p = 0; p < NR; p++) checkOutput($sformatf("cleared_x%0d", (a + p) % 32), p, 32'h0);
      nextCycle();
    end

    // Both ports to different addresses.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'h1234_5678);
    nextCycle();
    idle();
    setReads(5'd5, 5'd7, 5'd0);
    checkOutput("basic_x5", 0, 32'hDEAD_BEEF);
    checkOutput("basic_x7", 1, 32'h1234_5678);
    checkOutput("basic_x0", 2, 32'h0);
    checkReady("basic_ready", 1'b1);

    // Same-address collision: port 1 wins.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd9, 32'h5555_FFFF);
    setReads(5'd9, 5'd5, 5'd7);
`ifdef REGFILE_BYPASS_EN
    checkOutput("collide_same_cycle", 0, 32'h5555_FFFF);
`else
    checkOutput("collide_same_cycle", 0, 32'h0);
`endif
    checkOutput("collide_x5_kept", 1, 32'hDEAD_BEEF);
    checkOutput("collide_x7_kept", 2, 32'h1234_5678);
    nextCycle();
    idle();
    setReads(5'd9, 5'd9, 5'd9);
    for (int p = 0; p < NR; p++) checkOutput($sformatf("collide_x9_rd%0d", p), p, 32'h5555_FFFF);

    // Entry 0 ignores writes on both ports.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    setReads(5'd0, 5'd0, 5'd0);
    for (int p = 0; p < NR; p++) checkOutput($sformatf("x0_same_rd%0d", p), p, 32'h0);
    nextCycle();
    idle();
    for (int p = 0; p < NR; p++) checkOutput($sformatf("x0_after_rd%0d", p), p, 32'h0);

    // Same-cycle read of an address being written.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1111_1111, 1'b0, '0, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h00C0_FFEE, 1'b0, '0, '0);
    setReads(5'd3, 5'd3, 5'd0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_x3_same", 0, 32'h00C0_FFEE);
`else
    checkOutput("bypass_x3_same", 0, 32'h1111_1111);
`endif
    checkOutput("bypass_x0_same", 2, 32'h0);
    nextCycle();
    idle();
    checkOutput("bypass_x3_next", 0, 32'h00C0_FFEE);

    // Same-cycle read during a collision.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h0000_AAAA, 1'b1, 5'd6, 32'h0000_BBBB);
    setReads(5'd6, 5'd3, 5'd9);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_x6_collide", 0, 32'h0000_BBBB);
`else
    checkOutput("bypass_x6_collide", 0, 32'h0);
`endif
    nextCycle();
    idle();
    checkOutput("bypass_x6_next", 0, 32'h0000_BBBB);

    // Value later wiped by reset.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, '0, '0);
    nextCycle();
    idle();
    setReads(5'd12, 5'd13, 5'd14);
    checkOutput("pre_reset_x12", 0, 32'hCAFE_F00D);

    // Reset in READY together with writes, then a second reset at sweep cycle 10.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 5'd13, 32'h0000_0077, 1'b1, 5'd14, 32'h0000_0088);
    nextCycle();
    idle();
    for (int i = 0; i < 10; i++) begin
      checkReady($sformatf("resweep_ready_%0d", i), 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    checkReady("midsweep_rst_ready", 1'b0);
    nextCycle();
    idle();
    for (int i = 0; i < 31; i++) begin
      checkReady($sformatf("restart_ready_%0d", i), 1'b0);
      nextCycle();
    end
    checkReady("ready_after_restart", 1'b1);
    checkOutput("post_reset_x12", 0, 32'h0);
    checkOutput("post_reset_x13", 1, 32'h0);
    checkOutput("post_reset_x14", 2, 32'h0);

    // Let the monitor drain, then summarise.
    nextCycle();
    nextCycle();
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
